// File: rtl/sd1010_mux_sched.sv
// Round-robin time-shared "1010" non-overlapping Mealy detector for NCH serial channels.
// One granted bit per cycle advances that channel's saved 2-bit context; detections are reported with channel id.
module sd1010_mux_sched #(
    parameter int NCH = 4,
    parameter int CW  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCH-1:0]           req,
    input  logic [NCH-1:0]           din,
    input  logic [NCH-1:0]           clr,
    output logic [NCH-1:0]           ack,
    output logic                     hit,
    output logic [$clog2(NCH)-1:0]   hit_ch,
    output logic [CW-1:0]            hit_cnt
);

    localparam int IW = $clog2(NCH);

    typedef enum logic [1:0] {
        INIT = 2'b00,
        G1   = 2'b01,
        G10  = 2'b10,
        G101 = 2'b11
    } ctx_e;

    ctx_e            ctx_q [NCH];
    ctx_e            ctx_d [NCH];
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            hit_q, hit_d;
    logic [IW-1:0]   hit_ch_q, hit_ch_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NCH-1:0]  elig;
    logic            gnt_vld;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   cand;
    logic            det;

    function automatic ctx_e ctx_step(input ctx_e s, input logic b);
        case (s)
            INIT:    ctx_step = b ? G1   : INIT;
            G1:      ctx_step = b ? G1   : G10;
            G10:     ctx_step = b ? G101 : INIT;
            G101:    ctx_step = b ? G1   : INIT;
            default: ctx_step = INIT;
        endcase
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        sat_inc = (&v) ? v : v + 1'b1;
    endfunction

    // Search starts one past the last grant; ptr+NCH wraps back to ptr itself, so it is tried last.
    always_comb begin
        elig    = req & ~clr;
        gnt_vld = 1'b0;
        gnt_idx = ptr_q;
        cand    = ptr_q;
        if (!reset) begin
            for (int k = 1; k <= NCH; k++) begin
                cand = ptr_q + IW'(k);
                if (!gnt_vld && elig[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    assign ack = gnt_vld ? (NCH'(1) << gnt_idx) : '0;
    assign det = gnt_vld && (ctx_q[gnt_idx] == G101) && !din[gnt_idx];

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ctx_d[i] = ctx_q[i];
            if (clr[i]) begin
                ctx_d[i] = INIT;
            end else if (gnt_vld && (gnt_idx == IW'(i))) begin
                ctx_d[i] = ctx_step(ctx_q[i], din[i]);
            end
        end
        ptr_d    = gnt_vld ? gnt_idx : ptr_q;
        hit_d    = det;
        hit_ch_d = det ? gnt_idx : hit_ch_q;
        cnt_d    = det ? sat_inc(cnt_q) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                ctx_q[i] <= INIT;
            end
            ptr_q    <= IW'(NCH - 1);
            hit_q    <= 1'b0;
            hit_ch_q <= '0;
            cnt_q    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                ctx_q[i] <= ctx_d[i];
            end
            ptr_q    <= ptr_d;
            hit_q    <= hit_d;
            hit_ch_q <= hit_ch_d;
            cnt_q    <= cnt_d;
        end
    end

    assign hit     = hit_q;
    assign hit_ch  = hit_ch_q;
    assign hit_cnt = cnt_q;

endmodule

// File: tb/tb_sd1010_mux_sched.sv
// Bench for sd1010_mux_sched: vector table of per-cycle stimulus and expected grant/hit,
// with a hit scoreboard and a saturating-count model checked on a CW=8 and a CW=2 instance.
module tb_sd1010_mux_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] req, din, clr;
    logic [3:0] ack, ack2;
    logic       hit, hit2;
    logic [1:0] hit_ch, hit_ch2;
    logic [7:0] cnt;
    logic [1:0] cnt2;

    sd1010_mux_sched #(.NCH(4), .CW(8)) dut (
        .clk(clk), .reset(reset), .req(req), .din(din), .clr(clr),
        .ack(ack), .hit(hit), .hit_ch(hit_ch), .hit_cnt(cnt)
    );

    sd1010_mux_sched #(.NCH(4), .CW(2)) dut_sat (
        .clk(clk), .reset(reset), .req(req), .din(din), .clr(clr),
        .ack(ack2), .hit(hit2), .hit_ch(hit_ch2), .hit_cnt(cnt2)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] din;
        logic [3:0] clr;
        logic [3:0] ack;
        logic       hit;
        logic [1:0] ch;
    } vec_t;

    typedef struct {
        logic       hit;
        logic [1:0] ch;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] rq, input logic [3:0] d,
                       input logic [3:0] c, input logic [3:0] a, input logic h, input logic [1:0] ch);
        vec_t v;
        v.rst = rst; v.req = rq; v.din = d; v.clr = c; v.ack = a; v.hit = h; v.ch = ch;
        vecs.push_back(v);
    endtask

    // Single channel streams n bits (MSB first); hits marks which bit completes a detection.
    task automatic add_ser(input int ch, input logic [15:0] bits, input int n, input logic [15:0] hits);
        logic [3:0] oh;
        oh = 4'(1 << ch);
        for (int k = 0; k < n; k++) begin
            add(1'b0, oh, bits[n-1-k] ? oh : 4'b0000, 4'b0000, oh, hits[n-1-k], 2'(ch));
        end
    endtask

    task automatic add_rst();
        add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   exp_cnt;
        logic [1:0] last_ch;
        exp_t e;

        reset = 1'b1; req = '0; din = '0; clr = '0;
        exp_cnt = 0; last_ch = 2'd0;

        // Reset with every channel requesting: no grant.
        add(1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0);
        add_rst();
        // Single channel 1010.
        add_ser(0, 16'b1010, 4, 16'b0001);
        // Non-overlap: 1010 1010 on channel 2 -> two hits, "1010 10" alone only one.
        add_rst();
        add_ser(2, 16'b10101010, 8, 16'b00010001);
        // Interleaving four channels, each streaming 1010.
        add_rst();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                add(1'b0, 4'b1111, (r % 2 == 0) ? 4'b1111 : 4'b0000, 4'b0000,
                    4'(1 << c), (r == 3), 2'(c));
            end
        end
        // Pointer holds across an idle cycle.
        add_rst();
        add(1'b0, 4'b0110, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0);
        add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        add(1'b0, 4'b0111, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0);
        add(1'b0, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0);
        // Context isolation.
        add_rst();
        add_ser(1, 16'b101, 3, 16'b000);
        add_ser(3, 16'b00110, 5, 16'b00000);
        add_ser(1, 16'b0, 1, 16'b1);
        // Clear while requesting, clear skipping to next eligible, clear of a non-requester.
        add_rst();
        add_ser(0, 16'b101, 3, 16'b000);
        add(1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0);
        add(1'b0, 4'b0011, 4'b0000, 4'b0001, 4'b0010, 1'b0, 2'd0);
        add_ser(0, 16'b0, 1, 16'b0);
        add_ser(0, 16'b101, 3, 16'b000);
        add(1'b0, 4'b0010, 4'b0000, 4'b0001, 4'b0010, 1'b0, 2'd0);
        add_ser(0, 16'b0, 1, 16'b0);
        add_ser(0, 16'b1010, 4, 16'b0001);
        // Reset in the middle of a pattern.
        add_rst();
        add_ser(1, 16'b1010, 4, 16'b0001);
        add_ser(1, 16'b101, 3, 16'b000);
        add(1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        add_ser(1, 16'b0, 1, 16'b0);
        add_ser(1, 16'b1010, 4, 16'b0001);
        // Saturation: five hits, CW=2 instance counts 1,2,3,3,3.
        add_rst();
        for (int h = 0; h < 5; h++) add_ser(0, 16'b1010, 4, 16'b0001);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; req = vecs[i].req; din = vecs[i].din; clr = vecs[i].clr;
            #1;
            check("ack", i, 32'(ack), 32'(vecs[i].ack));
            check("ack_sat", i, 32'(ack2), 32'(vecs[i].ack));
            e.hit = vecs[i].hit; e.ch = vecs[i].ch;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            if (vecs[i].rst) begin
                exp_cnt = 0;
                last_ch = 2'd0;
            end else if (e.hit) begin
                exp_cnt++;
                last_ch = e.ch;
            end
            check("hit", i, 32'(hit), 32'(e.hit));
            check("hit_sat", i, 32'(hit2), 32'(e.hit));
            check("hit_ch", i, 32'(hit_ch), 32'(last_ch));
            check("hit_cnt", i, 32'(cnt), (exp_cnt > 255) ? 32'd255 : 32'(exp_cnt));
            check("hit_cnt_sat", i, 32'(cnt2), (exp_cnt > 3) ? 32'd3 : 32'(exp_cnt));
        end

        // Hit is a one-cycle pulse: idle cycle after the last detection.
        @(negedge clk);
        reset = 1'b0; req = '0; din = '0; clr = '0;
        @(posedge clk);
        #1;
        check("hit_pulse_end", vecs.size(), 32'(hit), 32'd0);
        check("hit_cnt_final", vecs.size(), 32'(cnt), 32'd5);
        check("hit_cnt_sat_final", vecs.size(), 32'(cnt2), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sd1010_mux_sched.md
# sd1010_mux_sched

Round-robin scheduler that time-shares one "1010" non-overlapping Mealy detector among NCH serial bit channels. Each cycle it grants one requesting channel, applies that channel's bit to the shared next-state logic using the channel's saved 2-bit context, and writes the result back. It sits between the serial front-ends and the event logic. It reports each detection with the channel id and keeps a saturating total hit count.

## Interface
Parameters:
- NCH, 4: number of channels; power of two, 2..8.
- CW, 8: width of the hit counter.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high.
- req, input, NCH: req[i]=1 means channel i offers bit din[i] this cycle.
- din, input, NCH: serial data bit per channel; valid only while req[i]=1.
- clr, input, NCH: clr[i]=1 forces channel i context to INIT at the next edge.
- ack, output, NCH: combinational one-hot grant; ack[i]=1 means din[i] is consumed at this edge. All zeros when there is no eligible request.
- hit, output, 1: registered; 1-cycle pulse when the granted bit completes 1010.
- hit_ch, output, log2(NCH): registered id of the channel that produced hit; holds its last value while hit=0.
- hit_cnt, output, CW: registered total hit count; saturates at all-ones.

## Operation
- Per-channel context ctx[i], 2 bits, with states INIT=00, G1=01, G10=10, G101=11.
- Eligible[i] = req[i] & ~clr[i]. A channel with clr asserted is never granted in that cycle, so its bit is neither consumed nor acked.
- Arbitration is round-robin over eligible channels:
  - The search starts at ptr+1 (mod NCH) and the first eligible index wins.
  - On a grant, ptr takes the granted index. With no grant, ptr holds.
- Detector transitions, applied only to the granted channel g with b=din[g]:
  - INIT: b=1 -> G1; b=0 -> INIT.
  - G1: b=0 -> G10; b=1 -> G1.
  - G10: b=1 -> G101; b=0 -> INIT.
  - G101: b=0 -> INIT and detect; b=1 -> G1.
- Non-overlapping: after a detect the context restarts from INIT, so "1010" followed by "10" does not detect again.
- Contexts of non-granted channels hold. clr[i] sets ctx[i]=INIT; clr has priority over everything else for that channel.
- On detect at edge k:
  - hit=1 and hit_ch=g during cycle k+1.
  - hit_cnt increments at edge k; it stays at 2^CW-1 once reached.
- No invalid encodings exist; there is no default path beyond INIT.

## Timing
- Reset, sampled at an edge: all ctx=INIT, ptr=NCH-1 (channel 0 has first priority), hit=0, hit_ch=0, hit_cnt=0.
- While reset=1, ack is forced to 0 and no context updates.
- reset in the middle of a pattern discards all partial context. The first pattern after reset needs a full 4 granted bits.
- ack latency is 0: combinational from req, clr, ptr and reset.
- hit latency is 1 cycle after the edge that consumes the final 0.
- Throughput is one bit per cycle total. With K channels continuously requesting, each channel is granted exactly once every K cycles.
- Simultaneous events:
  - clr[g] with req[g]: not granted, ctx cleared, the next eligible channel is granted.
  - Detect while hit_cnt is saturated: hit still pulses and the count holds.
  - A single requester is granted every cycle.

## Test plan
- Single channel: reset, then req[0]=1 streaming 1,0,1,0 -> ack[0]=1 for 4 cycles, hit=1 with hit_ch=0 one cycle after the 4th bit, hit_cnt=1.
- Non-overlap: channel 2 alone streams 1,0,1,0,1,0 -> exactly one hit; streaming 1,0,1,0,1,0,1,0 -> two hits; hit_cnt=2.
- Interleaving: channels 0..3 all request every cycle, each streaming 1010 -> grants go 0,1,2,3,0,1,...; four hits on consecutive cycles with hit_ch=0,1,2,3; hit_cnt=4.
- Context isolation: channel 1 sends 1,0,1, then idles 5 cycles while channel 3 sends 0,0,1,1,0, then channel 1 sends 0 -> a hit for channel 1 only.
- Clear and reset: channel 0 at G101, then clr[0]=1 with req[0]=1 and din=0 -> ack[0]=0, no hit, ctx[0]=INIT. Repeat with reset=1 instead -> all outputs and counters return to 0.
- Saturation: CW=2, produce 5 hits -> hit_cnt goes 1,2,3,3,3 and every hit still pulses.
